// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and reset constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam logic [3:0] STARVE_RST = 4'd0;
  localparam logic [7:0] RDATA_RST  = 8'h00;
  localparam logic [3:0] STARVE_SAT = 4'hF;

endpackage

// File: rtl/dmem_arb_select.sv
// dmem_arb_select: fixed CPU-priority winner pick with a DMA starvation guard.
// Grants are combinational and only offered while the sequencer is IDLE.
import dmem_arb_pkg::*;

module dmem_arb_select #(
  parameter int STARVE_MAX = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_cpu_req,
  input  logic   i_dma_req,
  input  logic   i_grant_fire,
  input  state_e i_state,
  output logic   o_cpu_gnt,
  output logic   o_dma_gnt,
  output owner_e o_owner
);

  logic [3:0] r_starve_cnt;
  logic       w_idle;
  logic       w_dma_force;

  assign w_idle      = (i_state == IDLE);
  assign w_dma_force = i_dma_req && (r_starve_cnt == 4'(STARVE_MAX));

  // Winner pick: CPU unless DMA is waiting and has been passed over STARVE_MAX times
  always_comb begin
    o_cpu_gnt = 1'b0;
    o_dma_gnt = 1'b0;
    if (w_idle) begin
      if (i_cpu_req && !w_dma_force) o_cpu_gnt = 1'b1;
      else if (i_dma_req)            o_dma_gnt = 1'b1;
    end
    o_owner = o_dma_gnt ? OWN_DMA : OWN_CPU;
  end

  // Starvation counter: counts CPU wins while DMA waits; cleared when DMA wins or withdraws
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                 r_starve_cnt <= STARVE_RST;
    else if (!i_dma_req)                       r_starve_cnt <= STARVE_RST;
    else if (i_grant_fire && o_dma_gnt)        r_starve_cnt <= STARVE_RST;
    else if (i_grant_fire && o_cpu_gnt &&
             r_starve_cnt != STARVE_SAT)       r_starve_cnt <= r_starve_cnt + 4'd1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between the CPU and a DMA
// port. Two-state sequencer (IDLE grants, ISSUE drives memory), registered
// read responses. Optional DMA write protection below PROT_LIMIT is built
// when DMEM_ARB_WPROT_EN is defined; otherwise o_dma_err is tied low.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = 8'h20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_write,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_e            r_state, w_next;
  owner_e            r_owner, w_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cpu_rvalid, r_dma_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata, r_dma_rdata;
  logic              w_cpu_gnt, w_dma_gnt, w_fire;
  logic              w_rd_done;
  logic              w_blk;

  assign w_fire    = (i_cpu_req && w_cpu_gnt) || (i_dma_req && w_dma_gnt);
  assign w_rd_done = (r_state == ISSUE) && !r_we;

  dmem_arb_select #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cpu_req   (i_cpu_req),
    .i_dma_req   (i_dma_req),
    .i_grant_fire(w_fire),
    .i_state     (r_state),
    .o_cpu_gnt   (w_cpu_gnt),
    .o_dma_gnt   (w_dma_gnt),
    .o_owner     (w_owner)
  );

  assign o_cpu_gnt = w_cpu_gnt;
  assign o_dma_gnt = w_dma_gnt;

  // State register; reset aborts any ISSUE in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: one grant moves to ISSUE, ISSUE always lasts a single cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fire) w_next = ISSUE;
      ISSUE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Memory strobes: driven only in ISSUE, all zero otherwise
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_write = 1'b0;
    o_mem_read  = 1'b0;
    if (r_state == ISSUE) begin
      o_mem_addr  = r_addr;
      o_mem_wdata = r_wdata;
      o_mem_write = r_we && !w_blk;
      o_mem_read  = !r_we;
    end
  end

  // Latch the winning request at the handshake edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner <= OWN_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_fire) begin
      r_owner <= w_owner;
      r_we    <= (w_owner == OWN_DMA) ? i_dma_we    : i_cpu_we;
      r_addr  <= (w_owner == OWN_DMA) ? i_dma_addr  : i_cpu_addr;
      r_wdata <= (w_owner == OWN_DMA) ? i_dma_wdata : i_cpu_wdata;
    end
  end

  // Read response: capture memory data at ISSUE exit, pulse rvalid for one cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_cpu_rdata  <= DATA_W'(RDATA_RST);
      r_dma_rdata  <= DATA_W'(RDATA_RST);
    end else begin
      r_cpu_rvalid <= w_rd_done && (r_owner == OWN_CPU);
      r_dma_rvalid <= w_rd_done && (r_owner == OWN_DMA);
      if (w_rd_done && r_owner == OWN_CPU) r_cpu_rdata <= i_mem_rdata;
      if (w_rd_done && r_owner == OWN_DMA) r_dma_rdata <= i_mem_rdata;
    end
  end

  assign o_cpu_rvalid = r_cpu_rvalid;
  assign o_dma_rvalid = r_dma_rvalid;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_dma_rdata  = r_dma_rdata;

`ifdef DMEM_ARB_WPROT_EN
  logic r_blk, r_dma_err;
  logic w_prot_hit;

  assign w_prot_hit = w_dma_gnt && i_dma_we && (i_dma_addr < PROT_LIMIT);

  // Protection: flag a blocked DMA write at grant, report it the cycle after ISSUE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blk     <= 1'b0;
      r_dma_err <= 1'b0;
    end else begin
      if (w_fire) r_blk <= w_prot_hit;
      r_dma_err <= (r_state == ISSUE) && r_blk;
    end
  end

  assign w_blk     = r_blk;
  assign o_dma_err = r_dma_err;
`else
  assign w_blk     = 1'b0;
  assign o_dma_err = 1'b0;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported 8-bit data memory. Shares the memory between the CPU load/store port and a DMA/debug port. Uses a req/gnt handshake, fixed CPU priority with a DMA starvation guard, a two-state access sequencer, and a registered read response. Sits between the CPU datapath/DMA engine and `data_memory`, and is the sole driver of its control inputs.

## Interface
- `ADDR_W`, 8, address width
- `DATA_W`, 8, data width
- `STARVE_MAX`, 4, maximum consecutive CPU grants while DMA waits (range 1..15)
- `PROT_LIMIT`, 8'h20, DMA write-protect bound (used only with macro)
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cpu_req`, `cpu_we`  in  1  CPU request; 1 = write
- `cpu_addr`, `cpu_wdata`  in  ADDR_W/DATA_W  CPU address and write data
- `cpu_gnt`  out  1  combinational grant; handshake completes at the edge where `req && gnt`
- `cpu_rvalid`  out  1  one-cycle read-response pulse
- `cpu_rdata`  out  DATA_W  read data, valid when `cpu_rvalid`
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`  as CPU set
- `dma_err`  out  1  one-cycle pulse: DMA write blocked
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  to memory
- `mem_write`, `mem_read`  out  1  memory strobes
- `mem_rdata`  in  DATA_W  memory read data (combinational read)

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: if any `req`, pick a winner and assert its `gnt`. At the edge, latch owner, we, addr and wdata, then go to ISSUE. With no `req`, stay in IDLE.
- Pick rule: CPU wins unless `dma_req` and `starve_cnt == STARVE_MAX`, in which case DMA wins.
- Starvation counter `starve_cnt` (4 bits):
  - +1 on each CPU grant while `dma_req` is high, saturating.
  - Clears on a DMA grant or whenever `dma_req` is low.
- ISSUE drives `mem_addr` and `mem_wdata` from the latched values.
  - `mem_read` = !we. `mem_write` = we.
  - The write lands at the ISSUE-exit edge.
  - At the same edge, `mem_rdata` is captured into the owner's rdata register and the owner's `rvalid` is set (reads only).
  - ISSUE always returns to IDLE.
- Responses:
  - `rvalid` is high for exactly the first IDLE cycle after a read ISSUE.
  - `rdata` holds its value until the next read for that owner.
  - Writes produce no `rvalid`.
- `gnt` is never asserted in ISSUE. At most one `gnt` is high per cycle.
- Outside ISSUE, all `mem_*` outputs are 0.

## Timing
- Reset values: state IDLE, `starve_cnt` 0, all `gnt`/`rvalid`/`mem_*`/`dma_err` 0, both rdata 8'h00.
- Read latency: grant edge plus 2 cycles. If granted in cycle 0, `rvalid` is asserted in cycle 2.
- Throughput: one access per 2 cycles. A new grant may occur in the same cycle as `rvalid`.
- `req` must be held with stable addr/we/wdata until `gnt`. Dropping `req` before `gnt` cancels the request with no effect.
- Reset asserted during ISSUE: `mem_write`/`mem_read` drop immediately, the pending write is lost, and no `rvalid` is produced.
- Simultaneous requests: CPU wins unless the starvation counter is full. The losing `req` stays pending.

## Configuration
- `DMEM_ARB_WPROT_EN` defined:
  - A granted DMA write with addr < `PROT_LIMIT` runs ISSUE with `mem_write` = 0.
  - `dma_err` pulses in the following cycle.
  - DMA reads and all CPU accesses are unaffected.
- Not defined: no protection logic; `dma_err` is tied 0.

## Structure
- Package `dmem_arb_pkg`: state enum (IDLE, ISSUE), owner enum (OWN_CPU, OWN_DMA), reset-value constants.
- Sub-module `dmem_arb_select`: winner pick plus starvation counter. Inputs: `req`s, `grant_fire`, state. Outputs: `gnt`s, owner.

## Test plan
- Memory preloaded 0x10=0xAA. CPU read 0x10 → `cpu_gnt` in cycle 0, `mem_read` in cycle 1, `cpu_rvalid` with `cpu_rdata`=0xAA in cycle 2.
- CPU write 0x30←0x5C, then DMA read 0x30 → `dma_rdata`=0x5C; `cpu_rvalid` never pulses.
- Both `req` held continuously, `STARVE_MAX`=4 → grant sequence CPU ×4, DMA ×1, repeating.
- `rst` pulsed during a write ISSUE to 0x31 → `mem_write` drops asynchronously, 0x31 keeps its old value, no `rvalid`.
- With macro: DMA write 0x12←0xFF → `mem_write` stays 0, `dma_err` pulses once, 0x12 keeps 0xCC. DMA write 0x40←0x11 succeeds.
- Without macro: same DMA write to 0x12 succeeds and `dma_err` stays 0.
